// File: rtl/prog_loader.sv
// Instruction-memory program loader: assembles a framed byte stream into
// 16-bit words, writes them from address 0, and releases the cpu on a good checksum.
module prog_loader #(
    parameter int unsigned AWIDTH = 8,
    parameter int unsigned DWIDTH = 16,
    parameter logic [7:0]  HDR    = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [7:0]        i_data,
    output logic              o_ready,
    output logic              o_mem_wr,
    output logic [AWIDTH-1:0] o_mem_waddr,
    output logic [DWIDTH-1:0] o_mem_wdata,
    output logic              o_cpu_rst,
    output logic              o_done,
    output logic              o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_HI,
        S_LO,
        S_WR,
        S_CSUM
    } state_e;

    state_e              state_q, state_d;
    logic [AWIDTH-1:0]   waddr_q, waddr_d;
    logic [DWIDTH-1:0]   wdata_q, wdata_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [7:0]          len_q, len_d;
    logic [7:0]          acc_q, acc_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                ready;
    logic                take;
    logic [8:0]          cnt_inc;

    assign ready   = (state_q != S_WR);
    assign take    = i_valid && ready;
    assign cnt_inc = {1'b0, cnt_q} + 9'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            waddr_q   <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            acc_q     <= '0;
            cpu_rst_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            acc_q     <= acc_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        acc_d     = acc_q;
        cpu_rst_d = cpu_rst_q;
        done_d    = done_q;
        err_d     = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (take && i_data == HDR) begin
                    state_d   = S_LEN;
                    cpu_rst_d = 1'b0;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    cnt_d     = '0;
                    acc_d     = '0;
                    waddr_d   = '0;
                end
            end
            S_LEN: begin
                if (take) begin
                    len_d   = i_data;
                    state_d = (i_data != 8'd0) ? S_HI : S_CSUM;
                end
            end
            S_HI: begin
                if (take) begin
                    wdata_d[DWIDTH-1 -: 8] = i_data;
                    acc_d   = acc_q ^ i_data;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (take) begin
                    wdata_d[7:0] = i_data;
                    acc_d   = acc_q ^ i_data;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                cnt_d = cnt_inc[7:0];
                if (cnt_inc == {1'b0, len_q}) begin
                    state_d = S_CSUM;
                end else begin
                    state_d = S_HI;
                    waddr_d = waddr_q + 1'b1;
                end
            end
            S_CSUM: begin
                // cpu is released only when the whole frame checks out
                if (take) begin
                    state_d = S_IDLE;
                    if (i_data == acc_q) begin
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_ready     = ready;
    assign o_mem_wr    = (state_q == S_WR);
    assign o_mem_waddr = waddr_q;
    assign o_mem_wdata = wdata_q;
    assign o_cpu_rst   = cpu_rst_q;
    assign o_done      = done_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames with hand-computed writes,
// checksum outcomes, stalls, reload and mid-frame reset.
module tb_prog_loader;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic [7:0]  i_data;
    logic        o_ready;
    logic        o_mem_wr;
    logic [7:0]  o_mem_waddr;
    logic [15:0] o_mem_wdata;
    logic        o_cpu_rst;
    logic        o_done;
    logic        o_err;

    int n_chk;
    int n_pass;
    int viol;
    int dup;
    bit gap;
    bit prev_wr;
    logic [7:0]  wa_q[$];
    logic [15:0] wd_q[$];

    prog_loader dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_ready    (o_ready),
        .o_mem_wr   (o_mem_wr),
        .o_mem_waddr(o_mem_waddr),
        .o_mem_wdata(o_mem_wdata),
        .o_cpu_rst  (o_cpu_rst),
        .o_done     (o_done),
        .o_err      (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst) begin
            if (o_mem_wr) begin
                wa_q.push_back(o_mem_waddr);
                wd_q.push_back(o_mem_wdata);
            end
            if (o_ready == o_mem_wr) viol++;
            if (prev_wr && o_mem_wr) dup++;
            prev_wr = o_mem_wr;
        end else begin
            prev_wr = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        if (gap) begin
            i_valid = 1'b0;
            @(posedge clk); #1;
        end
        i_valid = 1'b1;
        i_data  = b;
        n = 0;
        while (!o_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) check("ready_timeout", 32'(o_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int cycles);
        i_valid = 1'b0;
        repeat (cycles) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic clr();
        wa_q.delete();
        wd_q.delete();
        viol = 0;
        dup  = 0;
    endtask

    task automatic check_two(input string tag);
        check({tag, "_nwr"}, 32'(wa_q.size()), 32'd2);
        if (wa_q.size() == 2) begin
            check({tag, "_a0"}, 32'(wa_q[0]), 32'h00);
            check({tag, "_d0"}, 32'(wd_q[0]), 32'h1234);
            check({tag, "_a1"}, 32'(wa_q[1]), 32'h01);
            check({tag, "_d1"}, 32'(wd_q[1]), 32'hABCD);
        end
        check({tag, "_rdy"}, 32'(viol), 32'd0);
        check({tag, "_dup"}, 32'(dup), 32'd0);
    endtask

    task automatic frame_a(input logic [7:0] cs);
        send(8'hA5); send(8'h02);
        send(8'h12); send(8'h34);
        send(8'hAB); send(8'hCD);
        send(cs);
        i_valid = 1'b0;
    endtask

    task automatic check_rst(input string tag);
        check({tag, "_rdy"}, 32'(o_ready), 32'd1);
        check({tag, "_wr"}, 32'(o_mem_wr), 32'd0);
        check({tag, "_wa"}, 32'(o_mem_waddr), 32'd0);
        check({tag, "_wd"}, 32'(o_mem_wdata), 32'd0);
        check({tag, "_cpu"}, 32'(o_cpu_rst), 32'd0);
        check({tag, "_done"}, 32'(o_done), 32'd0);
        check({tag, "_err"}, 32'(o_err), 32'd0);
    endtask

    initial begin
        n_chk = 0; n_pass = 0; gap = 1'b0; prev_wr = 1'b0;
        rst = 1'b0; i_valid = 1'b0; i_data = 8'h00;
        clr();
        repeat (3) @(posedge clk);
        #1;
        check_rst("reset");
        rst = 1'b1;
        idle(2);

        frame_a(8'h40);
        check("f1_done", 32'(o_done), 32'd1);
        check("f1_cpu", 32'(o_cpu_rst), 32'd1);
        check("f1_err", 32'(o_err), 32'd0);
        idle(2);
        check_two("f1");

        clr();
        send(8'hA5);
        check("rl_cpu", 32'(o_cpu_rst), 32'd0);
        check("rl_done", 32'(o_done), 32'd0);
        send(8'h02);
        send(8'h12); send(8'h34);
        send(8'hAB); send(8'hCD);
        send(8'h41);
        i_valid = 1'b0;
        check("bad_err", 32'(o_err), 32'd1);
        check("bad_done", 32'(o_done), 32'd0);
        check("bad_cpu", 32'(o_cpu_rst), 32'd0);
        idle(2);
        check_two("bad");
        check("bad_hold", 32'(o_cpu_rst), 32'd0);

        clr();
        send(8'h00); send(8'hFF);
        send(8'hA5); send(8'h00); send(8'h00);
        i_valid = 1'b0;
        check("z_done", 32'(o_done), 32'd1);
        check("z_cpu", 32'(o_cpu_rst), 32'd1);
        check("z_err", 32'(o_err), 32'd0);
        idle(2);
        check("z_nwr", 32'(wa_q.size()), 32'd0);

        clr();
        send(8'hA5);
        check("rl2_cpu", 32'(o_cpu_rst), 32'd0);
        check("rl2_done", 32'(o_done), 32'd0);
        send(8'h01); send(8'hBE); send(8'hEF); send(8'h51);
        i_valid = 1'b0;
        check("rl2_done2", 32'(o_done), 32'd1);
        check("rl2_cpu2", 32'(o_cpu_rst), 32'd1);
        idle(2);
        check("rl2_nwr", 32'(wa_q.size()), 32'd1);
        if (wa_q.size() == 1) begin
            check("rl2_a0", 32'(wa_q[0]), 32'h00);
            check("rl2_d0", 32'(wd_q[0]), 32'hBEEF);
        end

        clr();
        gap = 1'b1;
        frame_a(8'h40);
        gap = 1'b0;
        check("gap_done", 32'(o_done), 32'd1);
        check("gap_cpu", 32'(o_cpu_rst), 32'd1);
        check("gap_err", 32'(o_err), 32'd0);
        idle(2);
        check_two("gap");

        clr();
        send(8'hA5); send(8'h02);
        send(8'h12); send(8'h34);
        send(8'hAB);
        i_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_rst("mid");
        check("mid_nwr", 32'(wa_q.size()), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(1);
        clr();
        frame_a(8'h40);
        check("post_done", 32'(o_done), 32'd1);
        check("post_cpu", 32'(o_cpu_rst), 32'd1);
        idle(2);
        check_two("post");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader; it is the write side of the instruction memory that the cpu fetch path reads.
- Receives a framed byte stream over a valid/ready handshake and assembles 16-bit instruction words.
- Writes the words sequentially into the instruction memory write port from address 0.
- Holds the cpu in reset until a complete frame with a correct checksum has been written.

Parameters:
- AWIDTH, 8, instruction memory address width.
- DWIDTH, 16, instruction word width; fixed at 2 bytes per word.
- HDR, 8'hA5, frame header byte.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- i_valid  input  1  byte valid from the stream source.
- i_data  input  8  stream byte.
- o_ready  output  1  loader accepts i_data this cycle. A transfer occurs when i_valid && o_ready at a rising edge.
- o_mem_wr  output  1  one-cycle write strobe to instruction memory.
- o_mem_waddr  output  AWIDTH  write address.
- o_mem_wdata  output  DWIDTH  write data.
- o_cpu_rst  output  1  active-low reset to the cpu; 0 holds the cpu.
- o_done  output  1  sticky: last frame loaded OK.
- o_err  output  1  sticky: last frame failed checksum.

Behaviour:
- Reset (rst=0, asynchronous):
  - State=IDLE.
  - o_ready=1, o_mem_wr=0, o_mem_waddr=0, o_mem_wdata=0.
  - o_cpu_rst=0, o_done=0, o_err=0.
  - Word counter, length register and checksum accumulator all 0.
- Frame format: HDR, LEN (word count N, 0..255), then N words each sent high byte first, then CSUM.
  - CSUM = XOR of all 2N data bytes; 8'h00 when N=0.
- States:
  - IDLE: o_ready=1. Non-HDR bytes are discarded. Accepting HDR:
    - next=LEN; o_cpu_rst<=0; o_done<=0; o_err<=0.
    - Clear counter and accumulator; o_mem_waddr<=0.
  - LEN: accept byte into length register. next=HI if N!=0, else CSUM.
  - HI: accept byte into o_mem_wdata[15:8]; accumulator ^= byte. next=LO.
  - LO: accept byte into o_mem_wdata[7:0]; accumulator ^= byte. next=WR.
  - WR: o_ready=0, o_mem_wr=1 for exactly this one cycle, with stable o_mem_waddr and o_mem_wdata.
    - Counter increments on exit.
    - next=CSUM if counter+1==N, else HI, with o_mem_waddr incremented at that edge.
  - CSUM: accept byte.
    - If it equals the accumulator: o_done<=1 and o_cpu_rst<=1 (cpu released the edge after acceptance).
    - Otherwise: o_err<=1 and o_cpu_rst stays 0.
    - next=IDLE in both cases.
- o_ready is 1 in every state except WR.
- Latency:
  - Write strobe occurs the cycle after the LO byte is accepted.
  - Max sustained rate is 3 cycles per word (HI, LO, WR) with i_valid held high.
- Byte 0xA5 inside LEN/HI/LO/CSUM is ordinary data; no resynchronisation mid-frame.
- Stalls: i_valid=0 in any accepting state holds state and all registers unchanged.
- Address: o_mem_waddr wraps modulo 2^AWIDTH. With N<=255 and AWIDTH=8 no wrap occurs.
- Reload: a new HDR accepted in IDLE while o_done=1 re-asserts the cpu hold (o_cpu_rst=0) on that edge.
- Error recovery: after an error the loader stays in IDLE with the cpu held, waiting for a new HDR.
- Reset mid-frame: immediate return to reset values; partially written memory is not cleared.
- o_mem_wr is never asserted outside WR.

Test Plan:
- Reset then stream A5,02,12,34,AB,CD,40 with i_valid held high.
  - Writes addr0=0x1234 and addr1=0xABCD, each a single-cycle o_mem_wr.
  - o_ready=0 only during the WR cycles.
  - o_done=1, o_cpu_rst=1 after the 0x40 byte; o_err=0.
- Same frame with CSUM=0x41 -> both writes occur; o_err=1, o_done=0, o_cpu_rst stays 0.
- Bytes 00,FF,A5,00,00 -> the first two bytes are ignored, zero writes, o_done=1, o_cpu_rst=1.
- After a successful load send A5 -> o_cpu_rst drops to 0 the edge after acceptance and o_done clears. Then 01,BE,EF,51 -> addr0=0xBEEF, o_done=1.
- Toggle i_valid every other cycle during the first frame -> identical write sequence and results; no duplicate or skipped bytes.
- Assert rst low after the HI byte of word 1 -> all outputs return to reset values; the next full frame loads correctly from addr0.
